// File: rtl/fpmul_rr_arbiter_if.sv
// Requester, multiplier and response bundle shared between fpmul_rr_arbiter and its environment.
// The arbiter takes the slave modport; the requesters/multiplier side takes master.
interface fpmul_rr_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  localparam int unsigned DATA_W = 32;

  logic [N_REQ-1:0]        REQ_VALID;
  logic [N_REQ-1:0]        REQ_READY;
  logic [DATA_W*N_REQ-1:0] REQ_A;
  logic [DATA_W*N_REQ-1:0] REQ_B;
  logic [DATA_W-1:0]       MUL_A;
  logic [DATA_W-1:0]       MUL_B;
  logic [DATA_W-1:0]       MUL_Z;
  logic [N_REQ-1:0]        RSP_VALID;
  logic [DATA_W-1:0]       RSP_Z;

  modport slave (
    input  REQ_VALID, REQ_A, REQ_B, MUL_Z,
    output REQ_READY, MUL_A, MUL_B, RSP_VALID, RSP_Z
  );

  modport master (
    output REQ_VALID, REQ_A, REQ_B, MUL_Z,
    input  REQ_READY, MUL_A, MUL_B, RSP_VALID, RSP_Z
  );
endinterface

// File: rtl/fpmul_rr_arbiter.sv
// Round-robin sharing of one free-running pipelined FP multiplier among N_REQ requesters.
// FPMUL_ARB_HOLD_OPERANDS_EN: when defined, idle cycles hold MUL_A/MUL_B instead of zeroing them.
module fpmul_rr_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned PIPE_LAT = 4,
  parameter int unsigned IDX_W    = 2
) (
  input  logic               CLK,
  input  logic               RST,
  fpmul_rr_arbiter_if.slave  bus
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SUM_W  = IDX_W + 1;

  logic [IDX_W-1:0]  r_ptr;
  logic [DATA_W-1:0] r_mul_a;
  logic [DATA_W-1:0] r_mul_b;
  logic              r_iss_vld;
  logic [IDX_W-1:0]  r_iss_idx;
  logic [PIPE_LAT-1:0] r_tag_vld;
  logic [IDX_W-1:0]  r_tag_idx [PIPE_LAT];

  logic              w_gnt_vld;
  logic [IDX_W-1:0]  w_gnt_idx;
  logic [N_REQ-1:0]  w_gnt_oh;
  logic [SUM_W-1:0]  w_scan_sum;
  logic [IDX_W-1:0]  w_scan_idx;
  logic [IDX_W-1:0]  w_ptr_nxt;
  logic [N_REQ-1:0]  w_rsp_vld;
  logic [DATA_W-1:0] w_req_a [N_REQ];
  logic [DATA_W-1:0] w_req_b [N_REQ];

  // Unpack the flat operand buses so the granted slice is a plain array select.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign w_req_a[gi] = bus.REQ_A[gi*DATA_W +: DATA_W];
    assign w_req_b[gi] = bus.REQ_B[gi*DATA_W +: DATA_W];
  end

  // Scan from the pointer with wrap; first valid requester wins.
  always_comb begin
    w_gnt_vld  = 1'b0;
    w_gnt_idx  = '0;
    w_gnt_oh   = '0;
    w_scan_sum = '0;
    w_scan_idx = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_scan_sum = SUM_W'(r_ptr) + SUM_W'(k);
      if (w_scan_sum >= SUM_W'(N_REQ)) begin
        w_scan_sum = w_scan_sum - SUM_W'(N_REQ);
      end
      w_scan_idx = w_scan_sum[IDX_W-1:0];
      if (!w_gnt_vld && !RST && bus.REQ_VALID[w_scan_idx]) begin
        w_gnt_vld            = 1'b1;
        w_gnt_idx            = w_scan_idx;
        w_gnt_oh[w_scan_idx] = 1'b1;
      end
    end
  end

  assign w_ptr_nxt = (w_gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : w_gnt_idx + IDX_W'(1);

  // Issue register; the issue tag travels alongside MUL_A/MUL_B into the tag pipe.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ptr     <= '0;
      r_mul_a   <= '0;
      r_mul_b   <= '0;
      r_iss_vld <= 1'b0;
      r_iss_idx <= '0;
    end else begin
      r_iss_vld <= w_gnt_vld;
      r_iss_idx <= w_gnt_idx;
      if (w_gnt_vld) begin
        r_ptr   <= w_ptr_nxt;
        r_mul_a <= w_req_a[w_gnt_idx];
        r_mul_b <= w_req_b[w_gnt_idx];
      end else begin
`ifdef FPMUL_ARB_HOLD_OPERANDS_EN
        r_mul_a <= r_mul_a;
        r_mul_b <= r_mul_b;
`else
        r_mul_a <= '0;
        r_mul_b <= '0;
`endif
      end
    end
  end

  // PIPE_LAT tag stages matching the multiplier latency from MUL_A/MUL_B to MUL_Z.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_tag_vld <= '0;
      for (int unsigned k = 0; k < PIPE_LAT; k++) begin
        r_tag_idx[k] <= '0;
      end
    end else begin
      r_tag_vld[0] <= r_iss_vld;
      r_tag_idx[0] <= r_iss_idx;
      for (int unsigned k = 1; k < PIPE_LAT; k++) begin
        r_tag_vld[k] <= r_tag_vld[k-1];
        r_tag_idx[k] <= r_tag_idx[k-1];
      end
    end
  end

  always_comb begin
    w_rsp_vld = '0;
    if (r_tag_vld[PIPE_LAT-1]) begin
      w_rsp_vld[r_tag_idx[PIPE_LAT-1]] = 1'b1;
    end
  end

  assign bus.REQ_READY = w_gnt_oh;
  assign bus.MUL_A     = r_mul_a;
  assign bus.MUL_B     = r_mul_b;
  assign bus.RSP_VALID = w_rsp_vld;
  assign bus.RSP_Z     = bus.MUL_Z;

endmodule

// File: tb/tb_fpmul_rr_arbiter.sv
// Self-checking bench for fpmul_rr_arbiter with a behavioural pipelined FP multiplier.
// Expected responses are queued at grant time and matched as RSP_VALID appears.
module tb_fpmul_rr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned P  = 4;
  localparam int unsigned IW = 2;
`ifdef FPMUL_ARB_HOLD_OPERANDS_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b0;

  fpmul_rr_arbiter_if #(.N_REQ(N)) bus ();

  fpmul_rr_arbiter #(.N_REQ(N), .PIPE_LAT(P), .IDX_W(IW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Normal-number FP multiply with truncation; test operands are exact.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [9:0]  e;
    logic [47:0] m;
    s = a[31] ^ b[31];
    if (a[30:0] == 31'h0 || b[30:0] == 31'h0) return {s, 31'h0};
    m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
    if (m[47]) begin
      e = e + 10'd1;
      return {s, e[7:0], m[46:24]};
    end
    return {s, e[7:0], m[45:23]};
  endfunction

  logic [31:0] z_pipe [P];
  always @(posedge CLK) begin
    z_pipe[0] <= fmul(bus.MUL_A, bus.MUL_B);
    for (int k = 1; k < P; k++) z_pipe[k] <= z_pipe[k-1];
  end
  assign bus.MUL_Z = z_pipe[P-1];

  typedef struct {
    int unsigned  due;
    logic [IW-1:0] idx;
    logic [31:0]  z;
  } exp_t;

  exp_t        sb [$];
  int unsigned ncyc;
  int          errors;
  int          checks;
  logic [31:0] op_a  [N];
  logic [31:0] op_b  [N];
  logic [31:0] exp_z [N];
  logic [IW-1:0] m_ptr;
  logic [31:0] m_mula;

  // Response monitor: every cycle RSP_VALID must match the scoreboard head or be zero.
  initial begin
    exp_t       e;
    logic [N-1:0] ev;
    ncyc = 0;
    forever begin
      @(negedge CLK);
      ncyc++;
      while (sb.size() > 0 && sb[0].due < ncyc) begin
        e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL rsp_missing: requester %0d response due at cycle %0d never matched (now %0d)",
                 e.idx, e.due, ncyc);
      end
      checks++;
      if (sb.size() > 0 && sb[0].due == ncyc) begin
        e = sb.pop_front();
        ev = '0;
        ev[e.idx] = 1'b1;
        if (bus.RSP_VALID !== ev || bus.RSP_Z !== e.z) begin
          errors++;
          $display("FAIL rsp_data: cycle %0d got valid=%b z=%h, expected valid=%b z=%h",
                   ncyc, bus.RSP_VALID, bus.RSP_Z, ev, e.z);
        end
      end else if (bus.RSP_VALID !== '0) begin
        errors++;
        $display("FAIL rsp_spurious: cycle %0d got valid=%b, expected 0", ncyc, bus.RSP_VALID);
      end
    end
  end

  // One cycle of stimulus; returns observed/model grant and the MUL_A seen after the edge.
  task automatic step(input logic [N-1:0] v,
                      output logic [N-1:0] rdy_obs, output logic [N-1:0] rdy_exp,
                      output logic [31:0] mula_obs, output logic [31:0] mula_exp);
    logic          found;
    logic [IW-1:0] gi;
    logic [IW-1:0] jj;
    bus.REQ_VALID = v;
    bus.REQ_A = {op_a[3], op_a[2], op_a[1], op_a[0]};
    bus.REQ_B = {op_b[3], op_b[2], op_b[1], op_b[0]};
    #1;
    rdy_obs = bus.REQ_READY;
    rdy_exp = '0;
    found = 1'b0;
    gi = '0;
    for (int k = 0; k < N; k++) begin
      jj = m_ptr + IW'(k);
      if (!found && v[jj]) begin
        found = 1'b1;
        gi = jj;
      end
    end
    if (found) begin
      rdy_exp[gi] = 1'b1;
      sb.push_back('{due: ncyc + 1 + P, idx: gi, z: exp_z[gi]});
      m_ptr = gi + IW'(1);
      mula_exp = op_a[gi];
    end else begin
      mula_exp = HOLD ? m_mula : 32'h0;
    end
    m_mula = mula_exp;
    @(posedge CLK);
    @(negedge CLK);
    mula_obs = bus.MUL_A;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    bus.REQ_VALID = '0;
    sb.delete();
    m_ptr = '0;
    m_mula = '0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic set_table();
    op_a[0] = 32'h40000000; op_b[0] = 32'h40400000; exp_z[0] = 32'h40C00000;
    op_a[1] = 32'h3FC00000; op_b[1] = 32'h40000000; exp_z[1] = 32'h40400000;
    op_a[2] = 32'h40800000; op_b[2] = 32'h3F000000; exp_z[2] = 32'h40000000;
    op_a[3] = 32'hC0000000; op_b[3] = 32'h3FC00000; exp_z[3] = 32'hC0400000;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    bus.REQ_VALID = '1;
    bus.REQ_A = '1;
    bus.REQ_B = '1;
    #1;
    checks += 3;
    if (bus.REQ_READY !== '0) begin
      errors++; $display("FAIL reset_ready: got %b expected 0", bus.REQ_READY);
    end
    if (bus.MUL_A !== 32'h0 || bus.MUL_B !== 32'h0) begin
      errors++; $display("FAIL reset_mul: got a=%h b=%h expected 0", bus.MUL_A, bus.MUL_B);
    end
    if (bus.RSP_VALID !== '0) begin
      errors++; $display("FAIL reset_rsp: got %b expected 0", bus.RSP_VALID);
    end
    @(negedge CLK);
    bus.REQ_VALID = '0;
    RST = 1'b0;
  endtask

  task automatic test_single();
    logic [N-1:0] ro, re;
    logic [31:0]  mo, me;
    int           lat;
    logic [31:0]  zobs;
    do_reset();
    op_a[2] = 32'h40000000; op_b[2] = 32'h40400000; exp_z[2] = 32'h40C00000;
    step('0, ro, re, mo, me);
    step(4'b0100, ro, re, mo, me);
    checks += 2;
    if (ro !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", ro); end
    if (mo !== 32'h40000000) begin errors++; $display("FAIL single_mula: got %h expected 40000000", mo); end
    lat = -1;
    zobs = '0;
    for (int k = 1; k <= 10; k++) begin
      step('0, ro, re, mo, me);
      if (lat < 0 && bus.RSP_VALID !== '0) begin
        lat = k;
        zobs = bus.RSP_Z;
      end
      checks++;
      if (mo !== me) begin errors++; $display("FAIL single_idle_mula: got %h expected %h", mo, me); end
    end
    checks += 2;
    if (lat != int'(P)) begin errors++; $display("FAIL single_latency: got %0d expected %0d", lat, P); end
    if (zobs !== 32'h40C00000) begin errors++; $display("FAIL single_z: got %h expected 40c00000", zobs); end
  endtask

  task automatic test_all_valid();
    logic [N-1:0] ro, re;
    logic [31:0]  mo, me;
    do_reset();
    set_table();
    for (int k = 0; k < 12; k++) begin
      step('1, ro, re, mo, me);
      checks += 2;
      if (ro !== (4'(1) << (k % N))) begin
        errors++; $display("FAIL all_ready: step %0d got %b expected %b", k, ro, 4'(1) << (k % N));
      end
      if (mo !== op_a[k % N]) begin
        errors++; $display("FAIL all_mula: step %0d got %h expected %h", k, mo, op_a[k % N]);
      end
    end
    repeat (P + 2) step('0, ro, re, mo, me);
  endtask

  task automatic test_wrap();
    logic [N-1:0] ro, re;
    logic [31:0]  mo, me;
    logic [N-1:0] wexp [3];
    wexp = '{4'b1000, 4'b0001, 4'b1000};
    do_reset();
    set_table();
    for (int k = 0; k < 3; k++) begin
      step(4'b0111, ro, re, mo, me);
      checks++;
      if (ro !== re) begin errors++; $display("FAIL wrap_setup: step %0d got %b expected %b", k, ro, re); end
    end
    for (int k = 0; k < 3; k++) begin
      step(4'b1001, ro, re, mo, me);
      checks += 2;
      if (ro !== wexp[k]) begin errors++; $display("FAIL wrap_ready: step %0d got %b expected %b", k, ro, wexp[k]); end
      if (mo !== me) begin errors++; $display("FAIL wrap_mula: step %0d got %h expected %h", k, mo, me); end
    end
    repeat (P + 2) step('0, ro, re, mo, me);
  endtask

  task automatic test_sparse();
    logic [N-1:0] ro, re;
    logic [31:0]  mo, me;
    logic [N-1:0] rv [12];
    do_reset();
    op_a[1] = 32'h3FC00000; op_b[1] = 32'h40000000; exp_z[1] = 32'h40400000;
    for (int k = 0; k < 12; k++) begin
      step((k == 0 || k == 2) ? 4'b0010 : 4'b0000, ro, re, mo, me);
      rv[k] = bus.RSP_VALID;
      if (k == 1) begin
        checks++;
        if (mo !== (HOLD ? 32'h3FC00000 : 32'h0)) begin
          errors++; $display("FAIL sparse_gap_mula: got %h expected %h", mo, HOLD ? 32'h3FC00000 : 32'h0);
        end
      end
    end
    checks += 3;
    if (rv[P] !== 4'b0010) begin errors++; $display("FAIL sparse_rsp1: got %b expected 0010", rv[P]); end
    if (rv[P+1] !== 4'b0000) begin errors++; $display("FAIL sparse_gap_rsp: got %b expected 0000", rv[P+1]); end
    if (rv[P+2] !== 4'b0010) begin errors++; $display("FAIL sparse_rsp2: got %b expected 0010", rv[P+2]); end
  endtask

  task automatic test_reset_midflight();
    logic [N-1:0] ro, re;
    logic [31:0]  mo, me;
    int           lat;
    set_table();
    repeat (3) step(4'b0111, ro, re, mo, me);
    repeat (2) step('0, ro, re, mo, me);
    RST = 1'b1;
    sb.delete();
    m_ptr = '0;
    m_mula = '0;
    #1;
    checks++;
    if (bus.RSP_VALID !== '0 || bus.MUL_A !== 32'h0) begin
      errors++; $display("FAIL midreset_flush: got rsp=%b mula=%h expected 0", bus.RSP_VALID, bus.MUL_A);
    end
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    for (int k = 0; k < 2 * P; k++) begin
      step('0, ro, re, mo, me);
      checks++;
      if (bus.RSP_VALID !== '0) begin
        errors++; $display("FAIL midreset_stale: cycle %0d got %b expected 0", k, bus.RSP_VALID);
      end
    end
    step(4'b0001, ro, re, mo, me);
    checks++;
    if (ro !== 4'b0001) begin errors++; $display("FAIL midreset_regrant: got %b expected 0001", ro); end
    lat = -1;
    for (int k = 1; k <= P + 3; k++) begin
      step('0, ro, re, mo, me);
      if (lat < 0 && bus.RSP_VALID === 4'b0001) lat = k;
    end
    checks++;
    if (lat != int'(P)) begin errors++; $display("FAIL midreset_latency: got %0d expected %0d", lat, P); end
  endtask

  task automatic test_idle();
    logic [N-1:0] ro, re;
    logic [31:0]  mo, me;
    logic [IW-1:0] ptr_before;
    ptr_before = m_ptr;
    for (int k = 0; k < 50; k++) begin
      step('0, ro, re, mo, me);
      checks++;
      if (ro !== '0) begin errors++; $display("FAIL idle_ready: cycle %0d got %b expected 0", k, ro); end
    end
    step('1, ro, re, mo, me);
    checks++;
    if (ro !== (4'(1) << ptr_before)) begin
      errors++; $display("FAIL idle_ptr_hold: got %b expected %b", ro, 4'(1) << ptr_before);
    end
    repeat (P + 2) step('0, ro, re, mo, me);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    bus.REQ_VALID = '0;
    bus.REQ_A = '0;
    bus.REQ_B = '0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0; op_b[i] = '0; exp_z[i] = '0;
    end
    m_ptr = '0;
    m_mula = '0;
    RST = 1'b1;
    test_reset();
    test_single();
    test_all_valid();
    test_wrap();
    test_sparse();
    test_reset_midflight();
    test_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
